// File: rtl/smac_pkg.sv
// Shared types and helpers for the SIMD multiply-accumulate unit.
// Contents: lane precision enum, FSM state enum, lane/accumulator width helpers,
//           select_precision legality and decode, operand extension for the multipliers.
package smac_pkg;

  typedef enum logic [1:0] {
    P8  = 2'd0,
    P16 = 2'd1,
    P32 = 2'd2
  } prec_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Widest supported lane; every slice is sized for it so lanes can be ganged.
  localparam int MAX_LW = 32;

  function automatic int lw_of(prec_e p);
    case (p)
      P8:      return 8;
      P16:     return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int acc_w(int lw, int guard_w);
    return 2 * lw + guard_w;
  endfunction

  function automatic logic onehot3(logic [2:0] s);
    return (s == 3'b001) || (s == 3'b010) || (s == 3'b100);
  endfunction

  // Only meaningful for legal (one-hot) encodings.
  function automatic prec_e prec_of(logic [2:0] s);
    if (s[2]) return P32;
    if (s[1]) return P16;
    return P8;
  endfunction

  // v holds a w-bit operand in its low bits with zeros above; returns it
  // sign- or zero-extended to 33 bits so one signed multiplier covers both cases.
  function automatic logic signed [32:0] ext_op(logic [31:0] v, int w, logic sgn);
    logic signed [32:0] t;
    int sh;
    t  = {1'b0, v};
    sh = 33 - w;
    if (sgn) t = (t <<< sh) >>> sh;
    return t;
  endfunction

endpackage

// File: rtl/smac_simd_if.sv
// Operand/result handshake bundle for smac_simd.
// master: operand source + result sink (drives beats, out_ready).
// slave : the MAC unit (drives in_ready, results, flags).
interface smac_simd_if #(
  parameter int DATA_W = 64
);
  logic [2:0]          select_precision;
  logic                is_signed;
  logic                in_valid;
  logic                in_ready;
  logic                in_last;
  logic [DATA_W-1:0]   input_data;
  logic [DATA_W-1:0]   weight;
  logic                out_valid;
  logic                out_ready;
  logic [2*DATA_W-1:0] res;
  logic                ovf;
  logic                err_sticky;

  modport master (
    output select_precision, is_signed, in_valid, in_last, input_data, weight, out_ready,
    input  in_ready, out_valid, res, ovf, err_sticky
  );

  modport slave (
    input  select_precision, is_signed, in_valid, in_last, input_data, weight, out_ready,
    output in_ready, out_valid, res, ovf, err_sticky
  );
endinterface

// File: rtl/smac_lane_acc.sv
// One accumulator slice: loads or adds a product, reduces the running sum to 2*LW bits.
// Latency: accumulator updates on en; red/ovf are combinational on the post-update sum.
// Backpressure: holds its sum whenever en is low.
// Ports: clk, rst_n, sclr, en, first (load instead of add), is_signed, prec,
//        prod (pre-extended product), red (2*LW-bit result, zero above), ovf (lane overflow).
// SMAC_SAT_EN defined: saturate out-of-range sums; undefined: wrap to the low 2*LW bits.
module smac_lane_acc
  import smac_pkg::*;
#(
  parameter int ACC_W = 72
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sclr,
  input  logic                    en,
  input  logic                    first,
  input  logic                    is_signed,
  input  prec_e                   prec,
  input  logic signed [ACC_W-1:0] prod,
  output logic [2*MAX_LW-1:0]     red,
  output logic                    ovf
);

  logic signed [ACC_W-1:0] acc_q, acc_d, keep;
  logic [2*MAX_LW-1:0]     mask, lo;
  logic                    fits;
  int                      w, sh;

  // No clear cycle between dot products: the first beat simply overwrites.
  assign acc_d = first ? prod : acc_q + prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      acc_q <= '0;
    else if (sclr)   acc_q <= '0;
    else if (en)     acc_q <= acc_d;
  end

  always_comb begin
    w    = 2 * lw_of(prec);
    sh   = ACC_W - w;
    // The sum fits in w bits iff re-extending its low w bits reproduces it.
    keep = is_signed ? ((acc_d <<< sh) >>> sh) : ((acc_d << sh) >> sh);
    fits = (keep == acc_d);
    mask = {(2*MAX_LW){1'b1}} >> (2*MAX_LW - w);
    lo   = acc_d[2*MAX_LW-1:0] & mask;
    ovf  = ~fits;
`ifdef SMAC_SAT_EN
    if (fits)           red = lo;
    else if (!is_signed) red = mask;
    else if (acc_d[ACC_W-1]) red = mask & ~(mask >> 1);
    else                red = mask >> 1;
`else
    red  = lo;
`endif
  end

endmodule

// File: rtl/smac_simd.sv
// Runtime-precision SIMD multiply-accumulate: 8/16/32-bit lanes, one packed widened result per dot product.
// Latency: in_last accepted at cycle t -> out_valid at t+3; one beat per cycle.
// Backpressure: whole pipeline stalls while a result is held unread (in_ready = ~out_valid | out_ready).
// Ports: clk, rst_n (async, active low), sclr (sync flush), bus (smac_simd_if.slave).
// Optional: SMAC_SAT_EN selects saturating lane reduction instead of wrapping.
module smac_simd
  import smac_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 256,
  parameter int GUARD_W   = $clog2(MAX_BEATS)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclr,
  smac_simd_if.slave bus
);

  localparam int NSLICE = DATA_W / 8;
  localparam int ACC_W  = acc_w(MAX_LW, GUARD_W);
  localparam int CNT_W  = $clog2(MAX_BEATS + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BEATS + 1);

  // ---------------- input stage / FSM ----------------
  state_e             state_q;
  prec_e              mode_q;
  logic               sign_q, err_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               adv, take, idle, legal, beat_sign;
  prec_e              beat_prec;
  logic               out_valid_q;

  assign adv          = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = adv;
  assign take         = bus.in_valid & adv;
  assign idle         = (state_q == IDLE);
  // Mode is only sampled on the opening beat; later beats reuse the latched one.
  assign legal        = ~idle | onehot3(bus.select_precision);
  assign beat_prec    = idle ? prec_of(bus.select_precision) : mode_q;
  assign beat_sign    = idle ? bus.is_signed : sign_q;
  // Saturates one past MAX_BEATS so the overflow condition stays visible until the last beat.
  assign cnt_d        = idle ? CNT_W'(1) : ((cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= P8;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (sclr) begin
      state_q <= IDLE;
      mode_q  <= P8;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (take) begin
      if (idle) begin
        if (legal) begin
          mode_q  <= beat_prec;
          sign_q  <= beat_sign;
          cnt_q   <= cnt_d;
          state_q <= bus.in_last ? IDLE : ACCUM;
        end else begin
          err_q   <= 1'b1;
        end
      end else begin
        cnt_q <= cnt_d;
        if (bus.in_last) state_q <= IDLE;
      end
    end
  end

  // ---------------- S1: operands + control ----------------
  logic              s1_vld_q, s1_first_q, s1_last_q, s1_over_q, s1_sign_q;
  prec_e             s1_prec_q;
  logic [DATA_W-1:0] s1_a_q, s1_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || sclr) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_over_q  <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_prec_q  <= P8;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (adv) begin
      s1_vld_q   <= take & legal;  // illegal opening beats are consumed but never enter the pipe
      s1_first_q <= idle;
      s1_last_q  <= bus.in_last;
      s1_over_q  <= (cnt_d > CNT_MAX);
      s1_sign_q  <= beat_sign;
      s1_prec_q  <= beat_prec;
      s1_a_q     <= bus.input_data;
      s1_b_q     <= bus.weight;
    end
  end

  // ---------------- S2: per-slice products ----------------
  // Slice k carries lane k of whatever precision is active; slices beyond the
  // lane count of a wide mode see zero operands.
  logic signed [ACC_W-1:0] prod_d [NSLICE];
  logic signed [ACC_W-1:0] prod_q [NSLICE];
  logic                    s2_vld_q, s2_first_q, s2_last_q, s2_over_q, s2_sign_q;
  prec_e                   s2_prec_q;

  for (genvar k = 0; k < NSLICE; k++) begin : g_mul
    logic [31:0]        a8, b8, a16, b16, a32, b32;
    logic signed [32:0] a_x, b_x;

    assign a8 = {24'b0, s1_a_q[8*k +: 8]};
    assign b8 = {24'b0, s1_b_q[8*k +: 8]};
    if (16*k < DATA_W) begin : g_h
      assign a16 = {16'b0, s1_a_q[16*k +: 16]};
      assign b16 = {16'b0, s1_b_q[16*k +: 16]};
    end else begin : g_hz
      assign a16 = '0;
      assign b16 = '0;
    end
    if (32*k < DATA_W) begin : g_w
      assign a32 = s1_a_q[32*k +: 32];
      assign b32 = s1_b_q[32*k +: 32];
    end else begin : g_wz
      assign a32 = '0;
      assign b32 = '0;
    end

    always_comb begin
      case (s1_prec_q)
        P8:      begin a_x = ext_op(a8,  8,  s1_sign_q); b_x = ext_op(b8,  8,  s1_sign_q); end
        P16:     begin a_x = ext_op(a16, 16, s1_sign_q); b_x = ext_op(b16, 16, s1_sign_q); end
        default: begin a_x = ext_op(a32, 32, s1_sign_q); b_x = ext_op(b32, 32, s1_sign_q); end
      endcase
    end

    assign prod_d[k] = {{(ACC_W-33){a_x[32]}}, a_x} * {{(ACC_W-33){b_x[32]}}, b_x};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || sclr) begin
      s2_vld_q   <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_over_q  <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_prec_q  <= P8;
      for (int k = 0; k < NSLICE; k++) prod_q[k] <= '0;
    end else if (adv) begin
      s2_vld_q   <= s1_vld_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      s2_over_q  <= s1_over_q;
      s2_sign_q  <= s1_sign_q;
      s2_prec_q  <= s1_prec_q;
      for (int k = 0; k < NSLICE; k++) prod_q[k] <= prod_d[k];
    end
  end

  // ---------------- S3: accumulate, reduce, pack ----------------
  logic [2*MAX_LW-1:0] red [NSLICE];
  logic [NSLICE-1:0]   lane_ovf;
  logic [2*DATA_W-1:0] res_d, res_q;
  logic                ovf_any, ovf_q;

  for (genvar k = 0; k < NSLICE; k++) begin : g_lane
    smac_lane_acc #(.ACC_W(ACC_W)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .sclr      (sclr),
      .en        (adv & s2_vld_q),
      .first     (s2_first_q),
      .is_signed (s2_sign_q),
      .prec      (s2_prec_q),
      .prod      (prod_q[k]),
      .red       (red[k]),
      .ovf       (lane_ovf[k])
    );
  end

  always_comb begin
    res_d   = '0;
    ovf_any = 1'b0;
    case (s2_prec_q)
      P8: for (int k = 0; k < NSLICE; k++) begin
        res_d[16*k +: 16] = red[k][15:0];
        ovf_any |= lane_ovf[k];
      end
      P16: for (int k = 0; k < NSLICE/2; k++) begin
        res_d[32*k +: 32] = red[k][31:0];
        ovf_any |= lane_ovf[k];
      end
      default: for (int k = 0; k < NSLICE/4; k++) begin
        res_d[64*k +: 64] = red[k];
        ovf_any |= lane_ovf[k];
      end
    endcase
  end

  // adv covers both "slot empty" and "held result retiring this cycle",
  // so a new result may replace a retiring one on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || sclr) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      if (s2_vld_q && s2_last_q) begin
        out_valid_q <= 1'b1;
        res_q       <= res_d;
        ovf_q       <= ovf_any | s2_over_q;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.res        = res_q;
  assign bus.ovf        = ovf_q;
  assign bus.err_sticky = err_q;

endmodule

// File: tb/tb_smac_simd.sv
module tb_smac_simd;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclr = 1'b0;
  always #5 clk = ~clk;

  smac_simd_if #(.DATA_W(64)) bus ();

  smac_simd #(.DATA_W(64), .MAX_BEATS(256), .GUARD_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sclr  (sclr),
    .bus   (bus)
  );

  typedef struct {
    logic [127:0] res;
    logic         ovf;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_res(input logic [127:0] r, input logic o, input string tag);
    exp_t e;
    e.res = r;
    e.ovf = o;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every handshaken result is popped and compared in order.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {127'b0, bus.out_valid}, 128'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.tag, "_res"}, bus.res, mon_e.res);
        check({mon_e.tag, "_ovf"}, {127'b0, bus.ovf}, {127'b0, mon_e.ovf});
      end
    end
  end

  // Drives one beat and returns #1 after the edge that accepted it.
  task automatic beat(input logic [63:0] a, input logic [63:0] b, input logic [2:0] sel,
                      input logic sgn, input logic last);
    int g;
    g = 0;
    bus.in_valid         = 1'b1;
    bus.input_data       = a;
    bus.weight           = b;
    bus.select_precision = sel;
    bus.is_signed        = sgn;
    bus.in_last          = last;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("beat_accept_timeout", {127'b0, bus.in_ready}, 128'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    repeat (5) @(negedge clk);
    while ((exp_q.size() != 0 || bus.out_valid === 1'b1) && g < 60) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_drained"}, 128'(exp_q.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_acc;
    int g;
    bus.in_valid         = 1'b0;
    bus.in_last          = 1'b0;
    bus.input_data       = '0;
    bus.weight           = '0;
    bus.select_precision = 3'b001;
    bus.is_signed        = 1'b0;
    bus.out_ready        = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {127'b0, bus.in_ready},   128'd1);
    check("rst_out_valid", {127'b0, bus.out_valid},  128'd0);
    check("rst_res",       bus.res,                  128'd0);
    check("rst_ovf",       {127'b0, bus.ovf},        128'd0);
    check("rst_err",       {127'b0, bus.err_sticky}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // INT8 signed single beat: 127*127 = 0x3F01, result three cycles after acceptance
    expect_res({8{16'h3F01}}, 1'b0, "int8_s_1beat");
    beat(64'h7F7F_7F7F_7F7F_7F7F, 64'h7F7F_7F7F_7F7F_7F7F, 3'b001, 1'b1, 1'b1);
    t_acc = cyc;
    g = 0;
    while (bus.out_valid !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("int8_latency", 128'(cyc - t_acc), 128'd2);
    drain("int8_s_1beat");

    // INT16 unsigned, 4 beats of 0x100*0x100
    expect_res({4{32'h0004_0000}}, 1'b0, "int16_u_4beat");
    for (int i = 0; i < 4; i++)
      beat(64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100, 3'b010, 1'b0, i == 3);
    drain("int16_u_4beat");

    // INT8 signed, 4 beats of -128*-128 = 65536 per lane
`ifdef SMAC_SAT_EN
    expect_res({8{16'h7FFF}}, 1'b1, "int8_ovf");
`else
    expect_res(128'd0, 1'b1, "int8_ovf");
`endif
    for (int i = 0; i < 4; i++)
      beat(64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080, 3'b001, 1'b1, i == 3);
    drain("int8_ovf");

    // Backpressure: result A held while product B sits in the pipe and beat C waits
    bus.out_ready = 1'b0;
    expect_res(128'h0002_0004_0006_0008_000A_000C_000E_0010, 1'b0, "bp_a");
    expect_res({64'd31, 64'hFFFF_FFFF_FFFF_FFDF}, 1'b0, "bp_b");
    expect_res({4{32'h3FFF_0001}}, 1'b0, "bp_c");
    beat(64'h0102_0304_0506_0708, 64'h0202_0202_0202_0202, 3'b001, 1'b0, 1'b1);
    beat({32'd10, 32'hFFFF_FFFB}, {32'd3, 32'd7}, 3'b100, 1'b1, 1'b0);
    beat({32'd1, 32'd1}, {32'd1, 32'd2}, 3'b100, 1'b1, 1'b1);
    fork
      beat(64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 3'b010, 1'b1, 1'b1);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("bp_in_ready",  {127'b0, bus.in_ready},  128'd0);
          check("bp_out_valid", {127'b0, bus.out_valid}, 128'd1);
          check("bp_res_hold",  bus.res, 128'h0002_0004_0006_0008_000A_000C_000E_0010);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("bp");

    // Mode lock: INT8 latched, second beat's 100 ignored; then an illegal IDLE beat is dropped
    expect_res({8{16'h0005}}, 1'b0, "mode_lock");
    beat(64'h0202_0202_0202_0202, 64'h0303_0303_0303_0303, 3'b001, 1'b1, 1'b0);
    beat(64'h0101_0101_0101_0101, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 1'b1, 1'b1);
    beat(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011, 1'b0, 1'b1);
    check("illegal_err_set", {127'b0, bus.err_sticky}, 128'd1);
    drain("mode_lock");

    // Async reset mid-ACCUM, then a fresh INT32 signed beat 3 * -2
    beat(64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002, 3'b010, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {127'b0, bus.out_valid},  128'd0);
    check("arst_in_ready",  {127'b0, bus.in_ready},   128'd1);
    check("arst_err_clr",   {127'b0, bus.err_sticky}, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_res({64'd0, 64'hFFFF_FFFF_FFFF_FFFA}, 1'b0, "arst_int32");
    beat({32'd0, 32'd3}, {32'd0, 32'hFFFF_FFFE}, 3'b100, 1'b1, 1'b1);
    drain("arst_int32");

    // sclr: clears err_sticky and an open product
    beat(64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101, 3'b000, 1'b0, 1'b1);
    check("sclr_err_pre", {127'b0, bus.err_sticky}, 128'd1);
    beat(64'h2020_2020_2020_2020, 64'h0505_0505_0505_0505, 3'b001, 1'b0, 1'b0);
    sclr = 1'b1;
    @(posedge clk);
    #1;
    sclr = 1'b0;
    check("sclr_err_clr",   {127'b0, bus.err_sticky}, 128'd0);
    check("sclr_out_valid", {127'b0, bus.out_valid},  128'd0);
    expect_res({8{16'h0100}}, 1'b0, "post_sclr");
    beat(64'h1010_1010_1010_1010, 64'h1010_1010_1010_1010, 3'b001, 1'b0, 1'b1);
    drain("post_sclr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/smac_simd.md
Name: smac_simd

Overview:
- Parametrised successor to the fixed-lane sub-multiplier.
- A runtime-precision SIMD multiply-accumulate unit: DATA_W-bit operand words are split into 8, 16 or 32-bit lanes.
- Each lane accumulates signed or unsigned products over a multi-beat dot product and emits one packed, widened result per dot product.
- Sits between the operand/weight fetch and the result write-back of each processing element.

Parameters:
- DATA_W, 64, operand word width; must be a multiple of 32.
- MAX_BEATS, 256, maximum beats per dot product.
- GUARD_W, $clog2(MAX_BEATS), accumulator guard bits per lane.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sclr  in  1  synchronous clear: flushes the pipeline, FSM to IDLE, out_valid=0
- select_precision  in  3  one-hot lane width: [0]=8, [1]=16, [2]=32
- is_signed  in  1  1 = signed lanes
- in_valid  in  1  operand beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_last  in  1  final beat of the dot product
- input_data  in  DATA_W  packed activations
- weight  in  DATA_W  packed weights
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- res  out  2*DATA_W  packed results; lane i at [2*LW*i +: 2*LW]
- ovf  out  1  per-result flag: any lane exceeded 2*LW bits, or the beat count exceeded MAX_BEATS
- err_sticky  out  1  illegal select_precision seen; cleared only by reset or sclr

Behaviour:
- Reset/sclr values: in_ready=1, out_valid=0, res=0, ovf=0, err_sticky=0, FSM=IDLE, all pipeline valids 0.
- Global advance enable: adv = ~out_valid | out_ready; in_ready = adv.
- Pipeline, all stages stall together when adv=0:
  - S1 registers operands plus control (first, last, mode, sign).
  - S2 forms LANES=DATA_W/LW products, each 2*LW wide, sign- or zero-extended per the latched sign.
  - S3 accumulates into per-lane ACC_W=2*LW+GUARD_W registers.
- Latency: in_last beat accepted at cycle t gives out_valid at t+3 when unstalled. Throughput is one beat per cycle.
- FSM at input stage:
  - IDLE: an accepted beat latches select_precision and is_signed, and marks first=1.
  - IDLE -> ACCUM when that beat has in_last=0; stays in IDLE when in_last=1 (single-beat product).
  - ACCUM: select_precision and is_signed are ignored and the latched mode is used. Beat counter increments.
  - ACCUM -> IDLE on an accepted in_last.
- Illegal select_precision (not one-hot) on an IDLE beat:
  - The beat is accepted and dropped; no accumulation.
  - err_sticky is set.
  - FSM stays IDLE.
- Accumulator: first=1 loads the product; otherwise acc += product. No clear cycle between dot products.
- Result on last beat in S3:
  - Each lane is reduced to 2*LW bits (see Optional Feature).
  - Lanes are packed into res; upper unused bits of res are 0.
  - out_valid is set, with ovf.
- res, ovf and out_valid hold stable until out_valid & out_ready.
- Beat counter: counts beats of the open product. On the beat where the count exceeds MAX_BEATS, ovf is forced for that result; the counter saturates and does not wrap.
- Simultaneous events:
  - out_ready while a new last reaches S3: the old result retires and the new one loads in the same cycle.
  - sclr wins over everything.
- Asynchronous reset mid-product discards the partial sum.

Optional Feature:
- Macro SMAC_SAT_EN.
- Defined: each lane result saturates to the signed or unsigned 2*LW range (signed 8-bit lanes clamp to [-32768, 32767]); ovf is set if any lane clamped.
- Undefined: lanes truncate to the low 2*LW bits (wrap); ovf is set if the discarded bits are not a pure sign/zero extension.

Decomposition:
- Shared package smac_pkg:
  - precision enum: P8, P16, P32.
  - lane-width function lw_of(prec).
  - FSM state enum: IDLE, ACCUM.
  - ACC_W computation.
  - one-hot legality function.
- One natural sub-module, smac_lane_acc: a single-lane accumulate-and-reduce slice (accumulate, saturate or truncate, ovf). It is instantiated DATA_W/8 times, and lanes are ganged by mode.

Test Plan:
- INT8 signed, 1 beat, all lanes input=0x7F, weight=0x7F, in_last=1 -> res lanes 0x3F01 (16-bit each), out_valid at t+3, ovf=0.
- INT16 unsigned, 4 beats, each beat lanes 0x0100 x 0x0100 -> each 32-bit lane = 0x00040000, out_valid once, after the 4th beat + 3.
- SMAC_SAT_EN defined, INT8 signed, 4 beats, lanes -128 x -128 -> 65536 clamps to 32767 per lane, ovf=1. Same test undefined -> lane=0x0000, ovf=1.
- Backpressure: out_ready=0 for 5 cycles with a second dot product in flight -> in_ready=0, res held unchanged. Release -> both results delivered in order, no lost beats.
- Mode lock: select_precision switched 001->100 mid-product -> result computed entirely as INT8. Next IDLE beat with 011 -> err_sticky=1, beat dropped.
- rst_n asserted mid-ACCUM, then one INT32 beat 3 x -2 signed -> lane0 = -6 (0xFFFFFFFFFFFFFFFA), no residue from the aborted sum.
